// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: register tags and scoreboard entries.
package hazard_pkg;

    localparam int unsigned SB_TAG_W = 6;
    localparam int unsigned SB_LAT_W = 4;

    // Tag = {is_fp, idx[4:0]}; integer x0 is hardwired and never a hazard.
    typedef logic [SB_TAG_W-1:0] tag_t;

    localparam tag_t TAG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        tag_t                tag;
        logic [SB_LAT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: decoded operands and pipeline destinations in, controls out.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LAT_W      = 4,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
);
    logic                          id_valid;
    logic [NUM_SRC*TAG_W-1:0]      id_src_tag;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [TAG_W-1:0]              id_dst_tag;
    logic                          id_dst_wr;
    logic                          id_mc;
    logic [LAT_W-1:0]              id_mc_lat;
    logic [FWD_STAGES*TAG_W-1:0]   stg_tag;
    logic [FWD_STAGES-1:0]         stg_wr;
    logic                          ex_mem_read;
    logic                          branch_taken;
    logic                          cnt_clr;

    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;
    logic                          if_id_flush;
    logic                          id_ex_bubble;
    logic                          mc_busy;
    logic                          mc_wb;
    logic [TAG_W-1:0]              mc_wb_tag;
    logic [31:0]                   stall_cnt;

    modport master (
        output id_valid, id_src_tag, id_src_used, id_dst_tag, id_dst_wr, id_mc, id_mc_lat,
               stg_tag, stg_wr, ex_mem_read, branch_taken, cnt_clr,
        input  fwd_sel, stall, if_id_flush, id_ex_bubble, mc_busy, mc_wb, mc_wb_tag, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_tag, id_src_used, id_dst_tag, id_dst_wr, id_mc, id_mc_lat,
               stg_tag, stg_wr, ex_mem_read, branch_taken, cnt_clr,
        output fwd_sel, stall, if_id_flush, id_ex_bubble, mc_busy, mc_wb, mc_wb_tag, stall_cnt
    );

endinterface

// File: rtl/hazard_fwd_match.sv
// Per-source forward priority encoder: youngest writing stage with a matching tag wins.
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic [TAG_W-1:0]            src_tag_i,
    input  logic                        src_used_i,
    input  logic [FWD_STAGES*TAG_W-1:0] stg_tag_i,
    input  logic [FWD_STAGES-1:0]       stg_wr_i,
    output logic [SEL_W-1:0]            sel_o,
    output logic                        ex_match_o
);

    logic [FWD_STAGES-1:0] match;

    // Raw tag match against every stage; x0 never forwards.
    always_comb begin
        match = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            match[k] = src_used_i && stg_wr_i[k] && (src_tag_i != TAG_W'(TAG_ZERO)) &&
                       (src_tag_i == stg_tag_i[k*TAG_W +: TAG_W]);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites the selection.
    always_comb begin
        sel_o = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (match[k]) sel_o = SEL_W'(FWD_STAGES - k);
        end
        ex_match_o = match[0];
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit with a fixed-latency multi-cycle scoreboard and stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned MC_DEPTH   = 4,
    parameter int unsigned LAT_W      = SB_LAT_W,
    parameter int unsigned TAG_W      = SB_TAG_W,
    parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave bus
);

    sb_entry_t                sb_q [MC_DEPTH];
    sb_entry_t                sb_d [MC_DEPTH];
    logic [MC_DEPTH-1:0]      sb_retire;
    logic [MC_DEPTH-1:0]      sb_block;
    logic [NUM_SRC-1:0]       src_ex_match;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic [LAT_W:0]           lat_p1;
    logic                     raw, waw, wb_conflict, load_use, stall, issue, alloc_done;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_fwd_match #(
            .FWD_STAGES(FWD_STAGES),
            .TAG_W     (TAG_W),
            .SEL_W     (SEL_W)
        ) u_match (
            .src_tag_i (bus.id_src_tag[i*TAG_W +: TAG_W]),
            .src_used_i(bus.id_src_used[i]),
            .stg_tag_i (bus.stg_tag),
            .stg_wr_i  (bus.stg_wr),
            .sel_o     (fwd_sel[i*SEL_W +: SEL_W]),
            .ex_match_o(src_ex_match[i])
        );
    end

    // Entry state: a retiring entry (cnt==1) is already on the writeback port, so it no
    // longer blocks readers, writers or the allocator.
    always_comb begin
        for (int j = 0; j < MC_DEPTH; j++) begin
            sb_retire[j] = sb_q[j].valid && (sb_q[j].cnt == SB_LAT_W'(1));
            sb_block[j]  = sb_q[j].valid && !sb_retire[j];
        end
    end

    // Hazard detection against the forwarding stages and the scoreboard.
    always_comb begin
        raw         = 1'b0;
        waw         = 1'b0;
        wb_conflict = 1'b0;
        lat_p1      = (LAT_W+1)'(bus.id_mc_lat) + (LAT_W+1)'(1);
        for (int j = 0; j < MC_DEPTH; j++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.id_src_used[i] && sb_block[j] &&
                    (bus.id_src_tag[i*TAG_W +: TAG_W] != TAG_ZERO) &&
                    (bus.id_src_tag[i*TAG_W +: TAG_W] == sb_q[j].tag)) begin
                    raw = 1'b1;
                end
            end
            if (bus.id_dst_wr && sb_block[j] && (bus.id_dst_tag != TAG_ZERO) &&
                (bus.id_dst_tag == sb_q[j].tag)) begin
                waw = 1'b1;
            end
            // A new op of latency L retires with an entry currently at L+1.
            if (sb_q[j].valid && ((LAT_W+1)'(sb_q[j].cnt) == lat_p1)) wb_conflict = 1'b1;
        end
        load_use = bus.ex_mem_read && (|src_ex_match);
        stall    = bus.id_valid &&
                   (load_use || raw || waw || (bus.id_mc && ((&sb_block) || wb_conflict)));
        issue    = bus.id_valid && bus.id_mc && !stall && !bus.branch_taken;
    end

    // Scoreboard next state: age live entries, then allocate the lowest free slot.
    always_comb begin
        alloc_done = 1'b0;
        for (int j = 0; j < MC_DEPTH; j++) begin
            sb_d[j] = sb_q[j];
            if (sb_retire[j]) begin
                sb_d[j].valid = 1'b0;
            end else if (sb_q[j].valid) begin
                sb_d[j].cnt = sb_q[j].cnt - SB_LAT_W'(1);
            end
        end
        for (int j = 0; j < MC_DEPTH; j++) begin
            if (issue && !alloc_done && !sb_d[j].valid) begin
                sb_d[j].valid = 1'b1;
                sb_d[j].tag   = bus.id_dst_tag;
                sb_d[j].cnt   = bus.id_mc_lat;
                alloc_done    = 1'b1;
            end
        end
    end

    // Saturating stall counter; clear has priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < MC_DEPTH; j++) sb_q[j] <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Writeback port and status outputs; at most one entry retires per cycle.
    always_comb begin
        bus.mc_wb     = 1'b0;
        bus.mc_wb_tag = '0;
        bus.mc_busy   = 1'b0;
        for (int j = 0; j < MC_DEPTH; j++) begin
            bus.mc_busy = bus.mc_busy || sb_q[j].valid;
            if (sb_retire[j]) begin
                bus.mc_wb     = 1'b1;
                bus.mc_wb_tag = sb_q[j].tag;
            end
        end
        bus.fwd_sel      = fwd_sel;
        bus.stall        = stall;
        bus.if_id_flush  = bus.branch_taken;
        bus.id_ex_bubble = bus.branch_taken || stall;
        bus.stall_cnt    = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_scoreboard_if hif ();

    hazard_scoreboard dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.id_valid     = 1'b0;
        hif.id_src_tag   = '0;
        hif.id_src_used  = '0;
        hif.id_dst_tag   = '0;
        hif.id_dst_wr    = 1'b0;
        hif.id_mc        = 1'b0;
        hif.id_mc_lat    = '0;
        hif.stg_tag      = '0;
        hif.stg_wr       = '0;
        hif.ex_mem_read  = 1'b0;
        hif.branch_taken = 1'b0;
        hif.cnt_clr      = 1'b0;
    endtask

    task automatic mc_issue(input logic [5:0] dst, input logic [3:0] lat);
        idle();
        hif.id_valid   = 1'b1;
        hif.id_mc      = 1'b1;
        hif.id_dst_wr  = 1'b1;
        hif.id_dst_tag = dst;
        hif.id_mc_lat  = lat;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        rst_n = 1'b0;
        step();
        step();
        // Reset state with all inputs low.
        check_val("rst_fwd_sel", 32'(hif.fwd_sel), 32'd0);
        check_val("rst_stall", 32'(hif.stall), 32'd0);
        check_val("rst_bubble", 32'(hif.id_ex_bubble), 32'd0);
        check_val("rst_flush", 32'(hif.if_id_flush), 32'd0);
        check_val("rst_busy", 32'(hif.mc_busy), 32'd0);
        check_val("rst_wb", 32'(hif.mc_wb), 32'd0);
        check_val("rst_wb_tag", 32'(hif.mc_wb_tag), 32'd0);
        check_val("rst_cnt", hif.stall_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        // Forward priority.
        hif.id_valid    = 1'b1;
        hif.id_src_tag  = {6'd5, 6'd0, 6'd5};
        hif.id_src_used = 3'b011;
        hif.stg_tag     = {6'd5, 6'd5};
        hif.stg_wr      = 2'b11;
        #1 check_val("fwd_youngest", 32'(hif.fwd_sel), 32'b00_00_10);
        hif.stg_wr = 2'b10;
        #1 check_val("fwd_stage1", 32'(hif.fwd_sel), 32'b00_00_01);
        hif.id_src_tag  = {6'd5, 6'd5, 6'd5};
        hif.id_src_used = 3'b011;
        hif.stg_wr      = 2'b11;
        #1 check_val("fwd_two_src", 32'(hif.fwd_sel), 32'b00_10_10);
        hif.id_src_tag  = '0;
        hif.id_src_used = 3'b111;
        hif.stg_tag     = '0;
        #1 check_val("fwd_x0", 32'(hif.fwd_sel), 32'd0);
        check_val("fwd_no_stall", 32'(hif.stall), 32'd0);

        // Load-use.
        idle();
        hif.id_valid    = 1'b1;
        hif.ex_mem_read = 1'b1;
        hif.stg_tag     = {6'd0, 6'd7};
        hif.stg_wr      = 2'b01;
        hif.id_src_tag  = {6'd0, 6'd7, 6'd0};
        hif.id_src_used = 3'b010;
        #1 check_val("lu_stall", 32'(hif.stall), 32'd1);
        check_val("lu_bubble", 32'(hif.id_ex_bubble), 32'd1);
        check_val("lu_cnt0", hif.stall_cnt, 32'd0);
        step();
        check_val("lu_cnt1", hif.stall_cnt, 32'd1);
        hif.id_src_used = 3'b000;
        #1 check_val("lu_unused", 32'(hif.stall), 32'd0);
        check_val("lu_unused_bub", 32'(hif.id_ex_bubble), 32'd0);
        hif.id_src_used = 3'b010;
        hif.id_valid    = 1'b0;
        #1 check_val("lu_gated", 32'(hif.stall), 32'd0);
        idle();
        hif.cnt_clr = 1'b1;
        step();
        hif.cnt_clr = 1'b0;
        check_val("cnt_cleared", hif.stall_cnt, 32'd0);

        // Multi-cycle RAW: lat 4 op at edge 0, dependent in ID from cycle 0.
        mc_issue(6'h23, 4'd4);
        #1 check_val("mc_issue_ok", 32'(hif.stall), 32'd0);
        step();
        idle();
        hif.id_valid    = 1'b1;
        hif.id_src_tag  = {6'd0, 6'd0, 6'h23};
        hif.id_src_used = 3'b001;
        #1 check_val("mc_busy", 32'(hif.mc_busy), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("raw_stall_c%0d", c), 32'(hif.stall), 32'd1);
            check_val($sformatf("raw_nowb_c%0d", c), 32'(hif.mc_wb), 32'd0);
            step();
        end
        check_val("raw_release", 32'(hif.stall), 32'd0);
        check_val("raw_wb", 32'(hif.mc_wb), 32'd1);
        check_val("raw_wb_tag", 32'(hif.mc_wb_tag), 32'h23);
        check_val("raw_cnt", hif.stall_cnt, 32'd3);
        step();
        check_val("raw_freed", 32'(hif.mc_busy), 32'd0);
        check_val("raw_wb_off", 32'(hif.mc_wb), 32'd0);

        // Structural: four long ops fill the scoreboard.
        for (int j = 0; j < 4; j++) begin
            mc_issue(6'(j + 1), 4'd15);
            #1 check_val($sformatf("fill_%0d", j), 32'(hif.stall), 32'd0);
            step();
        end
        mc_issue(6'd5, 4'd15);
        #1 check_val("struct_stall", 32'(hif.stall), 32'd1);
        hif.id_mc = 1'b0;
        #1 check_val("struct_non_mc", 32'(hif.stall), 32'd0);
        hif.id_dst_tag = 6'd2;
        #1 check_val("waw_stall", 32'(hif.stall), 32'd1);
        idle();
        // Reset mid-flight drops entries without waiting for a clock.
        #1 rst_n = 1'b0;
        #1 check_val("rst_mid_busy", 32'(hif.mc_busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Writeback-port conflict.
        mc_issue(6'd10, 4'd4);
        step();
        idle();
        step();
        mc_issue(6'd11, 4'd2);
        #1 check_val("wbc_lat2", 32'(hif.stall), 32'd1);
        hif.id_mc_lat = 4'd3;
        #1 check_val("wbc_lat3", 32'(hif.stall), 32'd0);
        step();
        idle();
        #1 check_val("wbc_none", 32'(hif.mc_wb), 32'd0);
        step();
        check_val("wbc_wb_a", 32'(hif.mc_wb_tag), 32'd10);
        step();
        check_val("wbc_wb_b_v", 32'(hif.mc_wb), 32'd1);
        check_val("wbc_wb_b", 32'(hif.mc_wb_tag), 32'd11);
        step();
        check_val("wbc_idle", 32'(hif.mc_busy), 32'd0);

        // Branch squashes issue but not in-flight ops.
        mc_issue(6'd12, 4'd3);
        step();
        mc_issue(6'd13, 4'd5);
        hif.branch_taken = 1'b1;
        #1 check_val("br_flush", 32'(hif.if_id_flush), 32'd1);
        check_val("br_bubble", 32'(hif.id_ex_bubble), 32'd1);
        check_val("br_no_stall", 32'(hif.stall), 32'd0);
        step();
        idle();
        hif.id_valid    = 1'b1;
        hif.id_src_tag  = {6'd0, 6'd0, 6'd13};
        hif.id_src_used = 3'b001;
        #1 check_val("br_no_alloc", 32'(hif.stall), 32'd0);
        hif.id_src_tag = {6'd0, 6'd0, 6'd12};
        #1 check_val("br_inflight", 32'(hif.stall), 32'd1);
        idle();
        step();
        check_val("br_wb", 32'(hif.mc_wb), 32'd1);
        check_val("br_wb_tag", 32'(hif.mc_wb_tag), 32'd12);
        step();
        check_val("br_done", 32'(hif.mc_busy), 32'd0);

        // Saturation and clear-over-increment with a held load-use stall.
        hif.id_valid    = 1'b1;
        hif.ex_mem_read = 1'b1;
        hif.stg_tag     = {6'd0, 6'd7};
        hif.stg_wr      = 2'b01;
        hif.id_src_tag  = {6'd0, 6'd7, 6'd0};
        hif.id_src_used = 3'b010;
        hif.cnt_clr     = 1'b1;
        step();
        hif.cnt_clr = 1'b0;
        check_val("clr_wins", hif.stall_cnt, 32'd0);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt_q;
        step();
        check_val("sat_fe", hif.stall_cnt, 32'hFFFF_FFFE);
        step();
        check_val("sat_ff", hif.stall_cnt, 32'hFFFF_FFFF);
        step();
        check_val("sat_hold", hif.stall_cnt, 32'hFFFF_FFFF);
        hif.cnt_clr = 1'b1;
        step();
        check_val("sat_clr", hif.stall_cnt, 32'd0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
